// File: rtl/reward_spawner.sv
// Reward offer initiator: draws LFSR positions/types and holds each offer until collected or expired.
// Outputs are registered; an offer appears one clk after the first valid candidate seen in DRAW.
module reward_spawner #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SPAWN_DELAY = 8,
  parameter int          LIFETIME    = 40,
  parameter int          X_MAX       = 24,
  parameter int          Y_MAX       = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_4hz,
  input  logic       enable,
  input  logic       set_finish,
  input  logic [4:0] mytank_xpos,
  input  logic [4:0] mytank_ypos,
  output logic       set_require,
  output logic [2:0] reward_type,
  output logic [4:0] random_xpos,
  output logic [4:0] random_ypos,
  output logic       dout,
  output logic [7:0] collected_cnt,
  output logic [7:0] expired_cnt
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  DELAY_N  = 8'(SPAWN_DELAY);
  localparam logic [7:0]  LIFE_N   = 8'(LIFETIME);
  localparam logic [4:0]  XM       = 5'(X_MAX);
  localparam logic [4:0]  YM       = 5'(Y_MAX);

  typedef enum logic [1:0] {IDLE, DELAY, DRAW, OFFER} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  tick_cnt_q, tick_cnt_inc;
  logic [4:0]  cx, cy;
  logic [2:0]  ct;
  logic        cand_ok;

  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cx      = lfsr_q[4:0];
    cy      = lfsr_q[9:5];
    ct      = {1'b0, lfsr_q[11:10]} + 3'd1;
    cand_ok = (cx != 5'd0) && (cx <= XM) && (cy != 5'd0) && (cy <= YM) &&
              !((cx == mytank_xpos) && (cy == mytank_ypos));
  end

  assign tick_cnt_inc = tick_cnt_q + 8'd1;
  assign dout         = lfsr_q[0];

  // The LFSR free-runs in every state so DRAW retries see a fresh candidate each clk.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED_EFF;
    else     lfsr_q <= lfsr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tick_cnt_q    <= 8'd0;
      set_require   <= 1'b0;
      reward_type   <= 3'd0;
      random_xpos   <= 5'd0;
      random_ypos   <= 5'd0;
      collected_cnt <= 8'd0;
      expired_cnt   <= 8'd0;
    end else if (!enable) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 8'd0;
      set_require <= 1'b0;
      reward_type <= 3'd0;
      random_xpos <= 5'd0;
      random_ypos <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= DELAY;
          tick_cnt_q <= 8'd0;
        end
        DELAY: begin
          if (tick_4hz) begin
            tick_cnt_q <= tick_cnt_inc;
            if (tick_cnt_inc == DELAY_N) state_q <= DRAW;
          end
        end
        DRAW: begin
          if (cand_ok) begin
            set_require <= 1'b1;
            reward_type <= ct;
            random_xpos <= cx;
            random_ypos <= cy;
            tick_cnt_q  <= 8'd0;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          // Collection takes priority over a coincident expiry strobe.
          if (set_finish) begin
            set_require <= 1'b0;
            reward_type <= 3'd0;
            random_xpos <= 5'd0;
            random_ypos <= 5'd0;
            tick_cnt_q  <= 8'd0;
            state_q     <= DELAY;
            if (collected_cnt != 8'hFF) collected_cnt <= collected_cnt + 8'd1;
          end else if (tick_4hz) begin
            tick_cnt_q <= tick_cnt_inc;
            if (tick_cnt_inc == LIFE_N) begin
              set_require <= 1'b0;
              reward_type <= 3'd0;
              random_xpos <= 5'd0;
              random_ypos <= 5'd0;
              tick_cnt_q  <= 8'd0;
              state_q     <= DELAY;
              if (expired_cnt != 8'hFF) expired_cnt <= expired_cnt + 8'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reward_spawner.md
Name: reward_spawner

Overview:
Initiator side of the reward handshake. It generates pseudo-random reward positions and types, and raises set_require to offer a reward on the map. The offer holds until the collector pulses set_finish or a lifetime timeout expires. The block sits between the reward collection logic (which drives set_finish) and the reward display, and runs in the system clk domain using a 4 Hz tick strobe.

Parameters:
SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.
SPAWN_DELAY, 8, number of tick_4hz strobes to wait before drawing a new reward.
LIFETIME, 40, number of tick_4hz strobes an offer stays live before it expires.
X_MAX, 24, largest legal reward x grid coordinate (legal range is 1..X_MAX).
Y_MAX, 18, largest legal reward y grid coordinate (legal range is 1..Y_MAX).

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous reset, active-high.
tick_4hz  in  1  one-clk-wide strobe at 4 Hz.
enable  in  1  reward system enable; when low the block is held idle.
set_finish  in  1  collector reports the reward was taken; level, sampled only in OFFER.
mytank_xpos  in  5  player tank grid x, used for spawn exclusion.
mytank_ypos  in  5  player tank grid y.
set_require  out  1  reward offer is live.
reward_type  out  3  1..4 while the offer is live, else 0.
random_xpos  out  5  1..X_MAX while the offer is live, else 0.
random_ypos  out  5  1..Y_MAX while the offer is live, else 0.
dout  out  1  LFSR bit 0, free-running random bit.
collected_cnt  out  8  number of offers completed by set_finish; saturates at 255.
expired_cnt  out  8  number of offers ended by timeout; saturates at 255.

Behaviour:
- Reset (sync, rst=1 at clk edge): lfsr=SEED (or 1 if SEED=0), state=IDLE, tick counter=0, all outputs 0.
- LFSR: 16-bit Fibonacci, shifts every clk regardless of state. new bit0 = b15^b13^b12^b10; shift left. dout=lfsr[0].
- Candidate: cx=lfsr[4:0], cy=lfsr[9:5], ct=lfsr[11:10]+1.
- A candidate is valid when 1<=cx<=X_MAX, 1<=cy<=Y_MAX, and !(cx==mytank_xpos && cy==mytank_ypos).
- FSM states IDLE, DELAY, DRAW, OFFER:
  - IDLE: outputs 0. enable=1 -> DELAY, tick counter cleared.
  - DELAY: count tick_4hz strobes. On the strobe that makes count==SPAWN_DELAY -> DRAW.
  - DRAW: each clk test the current candidate. If valid, register cx/cy/ct into the outputs, set set_require=1, clear the tick counter, -> OFFER. The outputs appear on the edge after the valid cycle. If invalid, stay in DRAW; the LFSR advances and a new candidate is tested next clk.
  - OFFER: random_xpos, random_ypos and reward_type are held stable.
    - set_finish=1 on any clk: set_require, type, xpos and ypos go to 0 on the next edge; collected_cnt++ (saturating) -> DELAY.
    - Otherwise count tick_4hz. On the strobe that makes count==LIFETIME: clear outputs, expired_cnt++ (saturating) -> DELAY.
- Simultaneous set_finish and expiry strobe: collection wins; only collected_cnt increments.
- set_finish outside OFFER is ignored. A set_finish held high across re-entry to OFFER counts again only after a fresh DELAY+DRAW; no edge detect is required.
- enable=0 in any state -> IDLE on the next edge with outputs cleared. An offer dropped this way counts as neither collected nor expired. Counters retain their values.
- rst mid-OFFER: all outputs 0 on the same edge; counters cleared.
- set_require is never 1 while any of reward_type, random_xpos or random_ypos is 0.

Test Plan:
- Reset and enable: rst for 2 clk, then enable=1, SPAWN_DELAY=8, with fast ticks every 4 clk -> set_require=0 through 8 strobes. set_require=1 within 1 clk of the first valid candidate after the 8th strobe. xpos in 1..24, ypos in 1..18, type in 1..4.
- Collection: during OFFER pulse set_finish for 1 clk -> next edge set_require=0 and position/type=0; collected_cnt=1; a new offer appears after 8 more strobes.
- Timeout: LIFETIME=40, no set_finish -> set_require drops exactly on the edge of the 40th strobe; expired_cnt=1; outputs held constant for the whole offer.
- Tank exclusion: force mytank to the first legal candidate from SEED=16'hACE1 -> that candidate is skipped, the offered position differs from the tank, and set_require is asserted at least 1 clk later than in the unexcluded run.
- Simultaneous events: set_finish on the same clk as the 40th strobe -> collected_cnt+1, expired_cnt unchanged. Separately, drop enable mid-OFFER -> IDLE next edge, both counters unchanged.
- Saturation and reset: run 260 collections -> collected_cnt=255. Then assert rst during OFFER -> all outputs 0 on the same edge.
